// File: rtl/vram_arbiter.sv
// vram_arbiter: three-state arbiter sharing one single-port pixel RAM between
// the VGA pixel reader and the CPU. VGA has priority, bounded by a starvation
// counter that forces a CPU grant after STARVE_LIMIT consecutive VGA grants
// while the CPU waits. Every grant lasts one cycle with the RAM bus registered.
// Optional feature: define VRAM_ARB_STATS_EN to build the CPU stall counter;
// otherwise stall_count is tied to zero.
module vram_arbiter #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_count
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    GNT_VGA,
    GNT_CPU
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SW-1:0]     starve_cnt;
  logic [SW-1:0]     starve_nxt;
  logic              cpu_busy;
  logic              starve_hit;
  logic              cpu_wr_ack;
  logic              cpu_rd_ack;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic              mem_we_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic [DATA_W-1:0] vga_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  assign cpu_ack = cpu_wr_ack | cpu_rd_ack;

  // RAM data arrives in the cycle after the read grant, so read data is passed
  // straight through in the valid/ack cycle and held in a register afterwards.
  assign vga_rdata = vga_rvalid ? mem_rdata : vga_rdata_q;
  assign cpu_rdata = cpu_rd_ack ? mem_rdata : cpu_rdata_q;

  // Next-state selection, starvation tracking and next RAM bus values
  always_comb begin
    // A CPU access is in flight from its grant cycle through its ack cycle;
    // for writes both fall in the same cycle.
    cpu_busy      = (state == GNT_CPU) || cpu_ack;
    starve_hit    = cpu_req && !cpu_busy && (starve_cnt == STARVE_MAX);
    state_nxt     = IDLE;
    starve_nxt    = starve_cnt;
    mem_addr_nxt  = mem_addr;
    mem_we_nxt    = 1'b0;
    mem_wdata_nxt = mem_wdata;

    if (vga_req && !starve_hit) begin
      state_nxt = GNT_VGA;
    end else if (cpu_req && !cpu_busy) begin
      state_nxt = GNT_CPU;
    end

    if (!cpu_req || (state_nxt == GNT_CPU)) begin
      starve_nxt = '0;
    end else if ((state_nxt == GNT_VGA) && (starve_cnt != STARVE_MAX)) begin
      starve_nxt = starve_cnt + SW'(1);
    end

    case (state_nxt)
      GNT_VGA: begin
        mem_addr_nxt = vga_addr;
      end
      GNT_CPU: begin
        mem_addr_nxt = cpu_addr;
        mem_we_nxt   = cpu_we;
        if (cpu_we) begin
          mem_wdata_nxt = cpu_wdata;
        end
      end
      default: begin
      end
    endcase
  end

  // Grant state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered RAM bus, response strobes and held read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt  <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      vga_rvalid  <= 1'b0;
      cpu_wr_ack  <= 1'b0;
      cpu_rd_ack  <= 1'b0;
      vga_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_we     <= mem_we_nxt;
      mem_wdata  <= mem_wdata_nxt;
      vga_rvalid <= (state == GNT_VGA);
      cpu_wr_ack <= (state_nxt == GNT_CPU) && cpu_we;
      cpu_rd_ack <= (state == GNT_CPU) && !mem_we;
      if (vga_rvalid) begin
        vga_rdata_q <= mem_rdata;
      end
      if (cpu_rd_ack) begin
        cpu_rdata_q <= mem_rdata;
      end
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic cpu_wait;

  assign cpu_wait = cpu_req && (state != GNT_CPU) && !cpu_ack;

  // Saturating count of cycles the CPU spends waiting for the RAM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (cpu_wait && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 18, pixel-memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, pixel colour width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, the most consecutive VGA grants allowed while a CPU request waits.
REQ-004 Port clk, input, 1, single block clock, rising-edge active.
REQ-005 Port rst, input, 1, asynchronous active-low reset.
REQ-006 Port vga_req, input, 1, pixel reader requests a read.
REQ-007 Port vga_addr, input, ADDR_W, pixel reader address.
REQ-008 Port vga_rdata, output, DATA_W, read data returned to the pixel reader.
REQ-009 Port vga_rvalid, output, 1, vga_rdata valid for one cycle.
REQ-010 Port cpu_req, input, 1, CPU requests an access; held until cpu_ack.
REQ-011 Port cpu_we, input, 1, 1 = write, 0 = read; stable while cpu_req is high.
REQ-012 Port cpu_addr, input, ADDR_W, CPU address; stable while cpu_req is high.
REQ-013 Port cpu_wdata, input, DATA_W, CPU write data.
REQ-014 Port cpu_ack, output, 1, one-cycle pulse; write committed, or read data valid on cpu_rdata.
REQ-015 Port cpu_rdata, output, DATA_W, CPU read data.
REQ-016 Ports mem_addr (output, ADDR_W), mem_we (output, 1), mem_wdata (output, DATA_W) and mem_rdata (input, DATA_W) form the single-port RAM interface; RAM read latency is 1 cycle.
REQ-017 Port stall_count, output, 16, saturating count of CPU wait cycles.

Function
REQ-018 The arbiter SHALL be a registered FSM with states IDLE, GNT_VGA and GNT_CPU; each grant occupies exactly one cycle, and the registered mem_* signals are driven in that cycle.
REQ-019 In any state, the next state SHALL be GNT_VGA if vga_req=1 and no starvation override applies; otherwise GNT_CPU if cpu_req=1 and no CPU access is in flight; otherwise IDLE.
REQ-020 A starvation override SHALL occur when the starve counter equals STARVE_LIMIT and cpu_req=1; in that case GNT_CPU is taken even if vga_req=1.
REQ-021 The starve counter SHALL increment on each GNT_VGA entry while cpu_req=1, and SHALL clear on GNT_CPU entry or when cpu_req=0.
REQ-022 In GNT_VGA, mem_we SHALL be 0; one cycle later, vga_rvalid=1 and vga_rdata=mem_rdata.
REQ-023 In GNT_CPU with cpu_we=1, mem_we=1 and mem_wdata=cpu_wdata; cpu_ack SHALL pulse in the same cycle.
REQ-024 In GNT_CPU with cpu_we=0, mem_we=0; one cycle later, cpu_ack=1 and cpu_rdata=mem_rdata.
REQ-025 A CPU access SHALL count as in flight from its grant until its cpu_ack; no second CPU grant is issued in that window.
REQ-026 On back-to-back CPU grants, the CPU SHALL drop cpu_req in the ack cycle, or the next access is granted on the following cycle; cpu_req seen in the ack cycle is not re-granted.
REQ-027 mem_we SHALL be 0 in IDLE; mem_addr holds its last value.
REQ-028 vga_rvalid and cpu_ack SHALL never both be 1 in the same cycle for the same grant; both may be high in one cycle only when the pulses come from different consecutive grants.
REQ-029 When both request in the same cycle with the starve counter below STARVE_LIMIT, VGA SHALL win.
REQ-030 vga_req asserted for one cycle SHALL be granted at most once; the arbiter does not queue VGA requests.

Reset
REQ-031 While rst=0, the state SHALL be IDLE, and the starve counter, mem_we, vga_rvalid, cpu_ack and stall_count SHALL be 0.
REQ-032 While rst=0, mem_addr, mem_wdata, vga_rdata and cpu_rdata SHALL be 0.
REQ-033 Reset asserted mid-access SHALL drop the access: no ack and no rvalid are issued after reset releases.
REQ-034 The first grant SHALL be no earlier than the first rising clk edge after rst goes high.

Configuration
REQ-035 With VRAM_ARB_STATS_EN defined, stall_count SHALL increment each cycle in which cpu_req=1 and no CPU grant or ack occurs, saturating at 16'hFFFF and clearing only on reset.
REQ-036 Without VRAM_ARB_STATS_EN defined, stall_count SHALL be constant 0 and no counter logic is synthesised.

Verification
REQ-037 CPU write only: cpu_req=1, we=1, addr=0x00010, wdata=0xA5 -> next cycle mem_we=1, mem_addr=0x00010, mem_wdata=0xA5, cpu_ack=1.
REQ-038 CPU read after write: same address, we=0, RAM returns 0xA5 -> cpu_ack and cpu_rdata=0xA5 two cycles after cpu_req rises.
REQ-039 Continuous vga_req with cpu_req held high, STARVE_LIMIT=4 -> 4 GNT_VGA, then 1 GNT_CPU, then VGA resumes.
REQ-040 Simultaneous first requests -> VGA granted first; CPU granted on the following cycle if vga_req drops.
REQ-041 rst pulled low in the cycle after a CPU read grant -> no cpu_ack, all outputs 0, IDLE after release.
REQ-042 With VRAM_ARB_STATS_EN defined, the REQ-039 pattern over 50 cycles -> stall_count equals the number of CPU wait cycles (40); without the macro, stall_count stays 0.
